// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register with valid/ready flow control. It carries a
//   control bundle, a destination register index and a payload from one
//   pipeline stage to the next. It supports back-pressure stalls and flush
//   (bubble insertion). An optional skid entry makes in_ready a pure register
//   output, which cuts the combinational ready path between stages.
//
//   Parameters
//     DATA_W  payload width
//     CTRL_W  control bundle width
//     RD_W    destination register index width
//     SKID    1: main + skid entry, registered in_ready
//             0: single entry, combinational in_ready
//
//   Ports
//     clk, rst           clock (rising edge), async active-high reset
//     flush              drop every held entry and any entry arriving now
//     in_valid/in_ready  upstream handshake
//     in_ctrl/rd/data    incoming entry
//     out_valid/ready    downstream handshake on the main entry
//     out_ctrl/rd/data   main entry; ctrl and rd read zero while invalid
//     occupancy          number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 5,
  parameter int RD_W   = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [RD_W-1:0]   out_rd,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  generate
    if (SKID != 0) begin : g_skid
      // State value equals the number of held entries.
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
      } state_t;

      state_t            state;
      logic              rdy_q;
      logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
      logic [RD_W-1:0]   main_rd,   skid_rd;
      logic [DATA_W-1:0] main_data, skid_data;
      logic              accept;
      logic              drain;

      assign accept = in_valid & rdy_q;
      assign drain  = (state != EMPTY) & out_ready;

      // NOTE: every register here is assigned with <= so all of them sample
      // the pre-edge values; mixing in = would make results order-dependent.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state     <= EMPTY;
          rdy_q     <= 1'b0;
          // NOTE: the payload registers are reset as well, because out_data
          // must read zero after reset, not just the control fields.
          main_ctrl <= '0;
          main_rd   <= '0;
          main_data <= '0;
          skid_ctrl <= '0;
          skid_rd   <= '0;
          skid_data <= '0;
        end else if (flush) begin
          // Payload is left alone: it is don't-care while out_valid=0.
          state     <= EMPTY;
          rdy_q     <= 1'b1;
          main_ctrl <= '0;
          main_rd   <= '0;
          skid_ctrl <= '0;
          skid_rd   <= '0;
        end else begin
          // Holds in every case except the FULL entry/exit transitions below.
          rdy_q <= (state != FULL);
          unique case (state)
            EMPTY: begin
              if (accept) begin
                main_ctrl <= in_ctrl;
                main_rd   <= in_rd;
                main_data <= in_data;
                state     <= MAIN;
              end
            end
            MAIN: begin
              if (accept && drain) begin
                main_ctrl <= in_ctrl;
                main_rd   <= in_rd;
                main_data <= in_data;
              end else if (drain) begin
                // Zero the control so a bubble never carries regWrite/memWrite.
                main_ctrl <= '0;
                main_rd   <= '0;
                state     <= EMPTY;
              end else if (accept) begin
                skid_ctrl <= in_ctrl;
                skid_rd   <= in_rd;
                skid_data <= in_data;
                state     <= FULL;
                rdy_q     <= 1'b0;
              end
            end
            FULL: begin
              // rdy_q is low here, so no new entry can arrive.
              if (drain) begin
                main_ctrl <= skid_ctrl;
                main_rd   <= skid_rd;
                main_data <= skid_data;
                skid_ctrl <= '0;
                skid_rd   <= '0;
                state     <= MAIN;
                rdy_q     <= 1'b1;
              end
            end
            default: state <= EMPTY;
          endcase
        end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state != EMPTY);
      assign out_ctrl  = main_ctrl;
      assign out_rd    = main_rd;
      assign out_data  = main_data;
      assign occupancy = state;
    end else begin : g_single
      logic              valid_q;
      logic [CTRL_W-1:0] main_ctrl;
      logic [RD_W-1:0]   main_rd;
      logic [DATA_W-1:0] main_data;
      logic              accept;
      logic              drain;

      // Ready when empty or draining this cycle; flush blocks the handshake.
      assign in_ready = (~valid_q | out_ready) & ~flush;
      assign accept   = in_valid & in_ready;
      assign drain    = valid_q & out_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q   <= 1'b0;
          main_ctrl <= '0;
          main_rd   <= '0;
          main_data <= '0;
        end else if (flush) begin
          valid_q   <= 1'b0;
          main_ctrl <= '0;
          main_rd   <= '0;
        end else if (accept) begin
          valid_q   <= 1'b1;
          main_ctrl <= in_ctrl;
          main_rd   <= in_rd;
          main_data <= in_data;
        end else if (drain) begin
          valid_q   <= 1'b0;
          main_ctrl <= '0;
          main_rd   <= '0;
        end
      end

      assign out_valid = valid_q;
      assign out_ctrl  = main_ctrl;
      assign out_rd    = main_rd;
      assign out_data  = main_data;
      assign occupancy = {1'b0, valid_q};
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Drives a SKID=1 and a SKID=0 instance from the same stimulus and compares
//   both against queue-based reference models of the stage contents.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;
  localparam int DW = 128;
  localparam int CW = 5;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [RW-1:0] in_rd;
  logic [DW-1:0] in_data;

  logic          s1_in_ready, s1_out_valid;
  logic [CW-1:0] s1_out_ctrl;
  logic [RW-1:0] s1_out_rd;
  logic [DW-1:0] s1_out_data;
  logic [1:0]    s1_occ;

  logic          s0_in_ready, s0_out_valid;
  logic [CW-1:0] s0_out_ctrl;
  logic [RW-1:0] s0_out_rd;
  logic [DW-1:0] s0_out_data;
  logic [1:0]    s0_occ;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .SKID(1)) dut_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s1_in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(s1_out_valid), .out_ready(out_ready),
    .out_ctrl(s1_out_ctrl), .out_rd(s1_out_rd), .out_data(s1_out_data),
    .occupancy(s1_occ)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .RD_W(RW), .SKID(0)) dut_single (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s0_in_ready),
    .in_ctrl(in_ctrl), .in_rd(in_rd), .in_data(in_data),
    .out_valid(s0_out_valid), .out_ready(out_ready),
    .out_ctrl(s0_out_ctrl), .out_rd(s0_out_rd), .out_data(s0_out_data),
    .occupancy(s0_occ)
  );

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  // Reference model: the ordered list of entries each stage holds.
  entry_t q1[$];
  entry_t q0[$];
  logic   rdy1;   // expected registered in_ready of the skid build

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic entry_t mk(input int unsigned c, input int unsigned r, input logic [DW-1:0] d);
    entry_t e;
    e.ctrl = CW'(c);
    e.rd   = RW'(r);
    e.data = d;
    return e;
  endfunction

  function automatic entry_t rand_entry();
    return mk($urandom, $urandom, {$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic compare_all();
    entry_t h1;
    entry_t h0;
    logic   rdy0;
    h1   = (q1.size() != 0) ? q1[0] : '0;
    h0   = (q0.size() != 0) ? q0[0] : '0;
    rdy0 = ((q0.size() == 0) || out_ready) && !flush;
    check("s1_out_valid", 128'(s1_out_valid), 128'(q1.size() != 0));
    check("s1_out_ctrl",  128'(s1_out_ctrl),  128'(h1.ctrl));
    check("s1_out_rd",    128'(s1_out_rd),    128'(h1.rd));
    if (q1.size() != 0) check("s1_out_data", s1_out_data, h1.data);
    check("s1_occupancy", 128'(s1_occ),       128'(q1.size()));
    check("s1_in_ready",  128'(s1_in_ready),  128'(rdy1));
    check("s0_out_valid", 128'(s0_out_valid), 128'(q0.size() != 0));
    check("s0_out_ctrl",  128'(s0_out_ctrl),  128'(h0.ctrl));
    check("s0_out_rd",    128'(s0_out_rd),    128'(h0.rd));
    if (q0.size() != 0) check("s0_out_data", s0_out_data, h0.data);
    check("s0_occupancy", 128'(s0_occ),       128'(q0.size()));
    check("s0_in_ready",  128'(s0_in_ready),  128'(rdy0));
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model at
  // the rising edge.
  task automatic step(input logic r, input logic fl, input logic iv, input logic ordy, input entry_t e);
    logic acc1, pop1, acc0, pop0;
    rst       = r;
    flush     = fl;
    in_valid  = iv;
    out_ready = ordy;
    {in_ctrl, in_rd, in_data} = e;
    if (r) begin
      q1.delete();
      q0.delete();
      rdy1 = 1'b0;
    end
    @(negedge clk);
    compare_all();
    @(posedge clk);
    if (r) begin
      q1.delete();
      q0.delete();
      rdy1 = 1'b0;
    end else if (fl) begin
      q1.delete();
      q0.delete();
      rdy1 = 1'b1;
    end else begin
      acc1 = iv && rdy1;
      pop1 = (q1.size() != 0) && ordy;
      acc0 = iv && ((q0.size() == 0) || ordy);
      pop0 = (q0.size() != 0) && ordy;
      if (pop1) void'(q1.pop_front());
      if (acc1) q1.push_back(e);
      rdy1 = (q1.size() < 2);
      if (pop0) void'(q0.pop_front());
      if (acc0) q0.push_back(e);
    end
    #1;
  endtask

  initial begin
    entry_t z;
    z = '0;

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, z);
    step(1'b0, 1'b0, 1'b0, 1'b1, z);   // in_ready still low before first edge
    step(1'b0, 1'b0, 1'b0, 1'b1, z);   // in_ready high after it

    // Stream of 8 entries at full throughput.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1, mk(5'b01010, i, DW'(i)));
    step(1'b0, 1'b0, 1'b0, 1'b1, z);
    step(1'b0, 1'b0, 1'b0, 1'b1, z);

    // Stream with a four-cycle downstream stall.
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b0, 1'b1, !(i >= 3 && i < 7), mk(5'b01010, 8 + i, DW'(100 + i)));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, z);

    // Fill to FULL, then flush with a new entry offered.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, rand_entry());
    step(1'b0, 1'b1, 1'b1, 1'b0, rand_entry());
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, z);

    // Flush in the same cycle an entry is accepted from MAIN.
    step(1'b0, 1'b0, 1'b1, 1'b0, rand_entry());
    step(1'b0, 1'b1, 1'b1, 1'b1, rand_entry());
    step(1'b0, 1'b0, 1'b0, 1'b1, z);

    // Fill to FULL, then assert reset between clock edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, rand_entry());
    #2;
    rst = 1'b1;
    #1;
    check("async_out_valid", 128'(s1_out_valid), 128'(0));
    check("async_out_ctrl",  128'(s1_out_ctrl),  128'(0));
    check("async_out_rd",    128'(s1_out_rd),    128'(0));
    check("async_out_data",  s1_out_data,        128'(0));
    check("async_occupancy", 128'(s1_occ),       128'(0));
    check("async_in_ready",  128'(s1_in_ready),  128'(0));
    q1.delete();
    q0.delete();
    rdy1 = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, z);
    step(1'b0, 1'b0, 1'b0, 1'b1, z);

    // out_ready toggled every cycle with continuous input.
    for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b1, i[0], rand_entry());
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, z);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1'b0, ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0), rand_entry());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
